// File: rtl/quad_pkg.sv
// Shared types and Gray-code step classification for the quadrature decoder.
package quad_pkg;

  typedef logic [1:0] ab_t;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam ab_t AB_00 = 2'b00;
  localparam ab_t AB_01 = 2'b01;
  localparam ab_t AB_11 = 2'b11;
  localparam ab_t AB_10 = 2'b10;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;

  // Next pair along the forward sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic ab_t fwd_next(input ab_t p);
    ab_t n;
    case (p)
      AB_00:   n = AB_01;
      AB_01:   n = AB_11;
      AB_11:   n = AB_10;
      default: n = AB_00;
    endcase
    return n;
  endfunction

  function automatic step_t step_dir(input ab_t prev, input ab_t cur);
    step_t s;
    ab_t   diff;
    diff      = prev ^ cur;
    s.illegal = (diff == 2'b11);
    s.valid   = (diff == 2'b01) || (diff == 2'b10);
    s.up      = (cur == fwd_next(prev));
    return s;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Per-channel synchronizer chain followed by a level-hold glitch filter.
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_acc,
  output logic acc_stb
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [3:0]             cnt_q;
  logic [3:0]             cnt_d;
  logic                   acc_q;
  logic                   stb_q;
  logic                   sync_out;

  assign sync_d[0] = d_in;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign cnt_d    = cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      stb_q  <= 1'b0;
      // Count only while the new level persists; any return restarts the count.
      if (sync_out != acc_q) begin
        if (cnt_d == 4'(FILTER_LEN)) begin
          acc_q <= sync_out;
          cnt_q <= '0;
          stb_q <= 1'b1;
        end else begin
          cnt_q <= cnt_d;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign d_acc   = acc_q;
  assign acc_stb = stb_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filtered A/B channels decoded into en/up strobes,
// a wrapping position count and a sticky illegal-transition flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             err_clr,
  output logic             en,
  output logic             up,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  // Long enough for a static pin level present at reset release to be accepted.
  localparam int       SETTLE      = SYNC_STAGES + FILTER_LEN + 1;
  localparam bit [4:0] SETTLE_LAST = 5'(SETTLE - 1);

  logic             a_acc, b_acc, a_stb, b_stb;
  ab_t              cur_ab;
  ab_t              prev_ab_q;
  state_t           state_q;
  logic [4:0]       init_cnt_q;
  logic             en_q, up_q, err_q;
  logic [WIDTH-1:0] pos_q, pos_d;
  step_t            step;
  logic             step_stb;

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .d_in(a_in), .d_acc(a_acc), .acc_stb(a_stb)
  );

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .d_in(b_in), .d_acc(b_acc), .acc_stb(b_stb)
  );

  assign cur_ab   = {a_acc, b_acc};
  assign step_stb = a_stb | b_stb;
  assign step     = step_dir(prev_ab_q, cur_ab);
  assign pos_d    = step.up ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      prev_ab_q  <= AB_00;
      en_q       <= 1'b0;
      up_q       <= 1'b1;
      pos_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_ab_q <= cur_ab;
      en_q      <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          if (init_cnt_q == SETTLE_LAST) begin
            state_q <= S_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + 5'd1;
          end
        end
        S_RUN: begin
          if (step_stb && step.valid) begin
            en_q  <= 1'b1;
            up_q  <= step.up;
            pos_q <= pos_d;
          end
        end
        default: state_q <= S_INIT;
      endcase
      // A new illegal transition outranks a simultaneous clear.
      if ((state_q == S_RUN) && step_stb && step.illegal) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign en  = en_q;
  assign up  = up_q;
  assign pos = pos_q;
  assign err = err_q;

endmodule
